// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// =============================================================================
// fifo_arb_pkg : shared types and width helpers for the FIFO write arbiter
// Revision 1.0
// =============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int bcnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    // Widths for the default configuration (DEPTH=8, MAX_BURST=4)
    localparam int LVL_W  = lvl_width(8);
    localparam int BCNT_W = bcnt_width(4);

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
`default_nettype none
// =============================================================================
// rr_pick : combinational round-robin picker, first requester after last_owner
// Revision 1.0
// =============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Scan starts one past the previous owner and wraps, so it gets lowest priority
    always_comb begin
        pick    = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// =============================================================================
// fifo_write_arbiter : round-robin burst arbiter for one FIFO write port,
//                      with occupancy tracking and a sticky flag-mismatch error
// Revision 1.0
// =============================================================================
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    input  logic                          fifo_r_en,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(DEPTH):0]        fifo_level,
    output logic                          level_err
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int LEVEL_W = lvl_width(DEPTH);
    localparam int CNT_W   = bcnt_width(MAX_BURST);

    localparam logic [LEVEL_W-1:0] C_LVL_MAX  = LEVEL_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]   C_OWN_RST  = IDX_W'(NUM_REQ - 1);

    arb_state_t           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_last_owner;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [LEVEL_W-1:0]   r_level;
    logic                 r_level_err;

    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_any;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_burst;
    logic                 w_beat;
    logic                 w_release;
    logic                 w_rd;
    logic                 w_wr;
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_owner (r_last_owner),
        .pick       (w_pick),
        .any        (w_any)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = IDX_W'(i);
            end
        end
    end

    // A full FIFO stalls the owner without releasing it or counting a beat
    assign w_burst   = (r_state == BURST);
    assign w_beat    = w_burst && req_valid[r_owner] && !fifo_full;
    assign w_release = w_burst &&
                       (!req_valid[r_owner] ||
                        (w_beat && (req_last[r_owner] || (r_beat_cnt == C_CNT_LAST))));

    assign req_ready    = (w_burst && !fifo_full) ? r_grant : '0;
    assign fifo_w_en    = w_beat;
    assign fifo_data_in = w_beat ? w_data_arr[r_owner] : '0;
    assign grant        = r_grant;
    assign fifo_level   = r_level;
    assign level_err    = r_level_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= C_OWN_RST;
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state    <= BURST;
                        r_grant    <= w_pick;
                        r_owner    <= w_pick_idx;
                        r_beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (w_release) begin
                        r_state      <= IDLE;
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        r_beat_cnt   <= '0;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Reads of an empty FIFO are ignored by the FIFO, so they do not count here
    assign w_rd = fifo_r_en && !fifo_empty;
    assign w_wr = fifo_w_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level     <= '0;
            r_level_err <= 1'b0;
        end else begin
            if (w_wr && !w_rd && (r_level != C_LVL_MAX)) begin
                r_level <= r_level + LEVEL_W'(1);
            end else if (w_rd && !w_wr && (r_level != '0)) begin
                r_level <= r_level - LEVEL_W'(1);
            end
            if ((fifo_empty && (r_level != '0)) || (fifo_full && (r_level != C_LVL_MAX))) begin
                r_level_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// =============================================================================
// tb_fifo_write_arbiter : scoreboard bench with a FIFO model, directed + random
// Revision 1.0
// =============================================================================
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int MB    = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid, req_last, req_ready, grant;
    logic [N*DW-1:0]     req_data;
    logic                fifo_w_en, fifo_full, fifo_empty, fifo_r_en, level_err;
    logic [DW-1:0]       fifo_data_in;
    logic [$clog2(DEPTH):0] fifo_level;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_w_en(fifo_w_en),
        .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_r_en(fifo_r_en), .grant(grant), .fifo_level(fifo_level), .level_err(level_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- producers and expected streams ----------------
    typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
    beat_t        pend [N][$];
    logic [DW-1:0] expq [N][$];
    logic [5:0]   seq [N];
    int           gap_prob = 0;
    int           rd_prob  = 0;
    bit           rd_pulse = 1'b0;
    bit           force_empty = 1'b0;
    logic [N-1:0] drv_fire;

    task automatic push_beat(input int i, input logic [DW-1:0] d, input logic l);
        pend[i].push_back({l, d});
        expq[i].push_back(d);
    endtask

    // Data carries the producer index in its top two bits so order can be checked per producer
    task automatic push_pkt(input int i, input int len, input bit nolast);
        logic [1:0] id;
        id = i[1:0];
        for (int k = 0; k < len; k++) begin
            push_beat(i, {id, seq[i]}, !nolast && (k == len - 1));
            seq[i] += 6'd1;
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            expq[i].delete();
        end
    endtask

    initial begin
        req_valid = '0; req_last = '0; req_data = '0; fifo_r_en = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = 6'd0;
        forever begin
            @(negedge clk);
            drv_fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                req_valid = '0; req_last = '0; req_data = '0; fifo_r_en = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (drv_fire[i] && pend[i].size() > 0) void'(pend[i].pop_front());
                    if (req_valid[i] && !drv_fire[i] && pend[i].size() > 0) begin
                        // hold: valid and data stay stable until accepted
                    end else if (pend[i].size() > 0 && $urandom_range(99) >= gap_prob) begin
                        req_valid[i] = 1'b1;
                        req_last[i]  = pend[i][0].last;
                        req_data[i*DW +: DW] = pend[i][0].data;
                    end else begin
                        req_valid[i] = 1'b0;
                        req_last[i]  = 1'b0;
                        req_data[i*DW +: DW] = '0;
                    end
                end
                fifo_r_en = rd_pulse || (rd_prob > 0 && $urandom_range(99) < rd_prob);
                rd_pulse  = 1'b0;
            end
        end
    end

    // ---------------- FIFO model: full at DEPTH-1 entries ----------------
    logic [DW-1:0] mq [$];
    int m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_count <= 0;
        end else begin
            if (fifo_r_en && m_count != 0) void'(mq.pop_front());
            if (fifo_w_en && m_count != DEPTH - 1) mq.push_back(fifo_data_in);
            m_count <= m_count + ((fifo_w_en && m_count != DEPTH - 1) ? 1 : 0)
                               - ((fifo_r_en && m_count != 0) ? 1 : 0);
        end
    end

    assign fifo_full  = (m_count == DEPTH - 1);
    assign fifo_empty = (m_count == 0) || force_empty;

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && fifo_w_en) begin
                int id;
                id = int'(fifo_data_in[DW-1 -: 2]);
                if (expq[id].size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_extra: got %0h expected none from producer %0d", fifo_data_in, id);
                end else begin
                    chk("sb_data", fifo_data_in, expq[id].pop_front());
                end
            end
        end
    end

    // ---------------- protocol reference model ----------------
    function automatic int rr_next(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [N-1:0] g);
        for (int j = 0; j < N; j++) if (g[j]) return j;
        return -1;
    endfunction

    bit           prev_ok = 1'b0;
    logic [N-1:0] p_grant = '0;
    logic [N-1:0] p_valid = '0;
    bit           exp_rel = 1'b0;
    bit           m_err = 1'b0;
    int           m_last = N - 1;
    int           bcnt = 0;
    int           cyc = 0;
    int           glog [$];
    int           gcyc [$];
    int           blog [$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_ok = 1'b0; p_grant = '0; m_last = N - 1; bcnt = 0; m_err = 1'b0;
            end else begin
                if (prev_ok) begin
                    if (p_grant == '0) begin
                        int e;
                        e = rr_next(p_valid, m_last);
                        chk("rr_grant", grant, (e < 0) ? 0 : (1 << e));
                        if (grant != '0) begin
                            glog.push_back(oh2i(grant));
                            gcyc.push_back(cyc);
                        end
                    end else begin
                        chk("release", grant == '0, exp_rel);
                        if (grant != '0) chk("grant_hold", grant, p_grant);
                        else m_last = oh2i(p_grant);
                    end
                    chk("level", fifo_level, m_count);
                    chk("level_err", level_err, m_err);
                end
                chk("ready", req_ready, fifo_full ? '0 : grant);
                chk("w_en", fifo_w_en, |(req_valid & req_ready));
                chk("grant_onehot", $onehot0(grant), 1);
                if (!fifo_w_en) chk("data_idle", fifo_data_in, 0);
                if (grant != '0) begin
                    int g;
                    g = oh2i(grant);
                    exp_rel = !req_valid[g] || (fifo_w_en && (req_last[g] || bcnt + 1 == MB));
                    if (exp_rel) begin
                        blog.push_back(bcnt + (fifo_w_en ? 1 : 0));
                        bcnt = 0;
                    end else if (fifo_w_en) begin
                        bcnt++;
                    end
                end
                if ((fifo_empty && m_count != 0) || (fifo_full && m_count != DEPTH - 1)) m_err = 1'b1;
                p_grant = grant;
                p_valid = req_valid;
                prev_ok = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        clear_queues();
        force_empty = 1'b0; rd_prob = 0; gap_prob = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_level(input int lv, input int maxc, input string nm);
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (fifo_level == lv) return;
        end
        total++; bad++;
        $display("FAIL %s: timeout, level=%0d expected %0d", nm, fifo_level, lv);
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input int maxc, input string nm);
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (grant == g) return;
        end
        total++; bad++;
        $display("FAIL %s: timeout, grant=%0h expected %0h", nm, grant, g);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        for (int c = 0; c < maxc; c++) begin
            int p;
            @(negedge clk);
            p = 0;
            for (int i = 0; i < N; i++) p += pend[i].size();
            if (p == 0 && req_valid == '0 && grant == '0 && m_count == 0) return;
        end
        total++; bad++;
        $display("FAIL %s: timeout draining, level=%0d", nm, fifo_level);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wcnt;
        #1;
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wen", fifo_w_en, 0);
        chk("rst_data", fifo_data_in, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_err", level_err, 0);
        do_reset();

        // 1: single producer, three beats
        @(negedge clk);
        push_beat(0, 8'h11, 1'b0); push_beat(0, 8'h22, 1'b0); push_beat(0, 8'h33, 1'b1);
        @(negedge clk);
        chk("t1_latency", grant, 4'b0000);
        wcnt = 0;
        @(negedge clk);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_first", fifo_data_in, 8'h11);
        wcnt += fifo_w_en ? 1 : 0;
        repeat (2) begin @(negedge clk); wcnt += fifo_w_en ? 1 : 0; end
        @(negedge clk);
        chk("t1_wcount", wcnt, 3);
        chk("t1_idle", grant, 0);
        chk("t1_level", fifo_level, 3);

        // 2: all producers streaming, bursts capped
        do_reset();
        glog.delete(); gcyc.delete(); blog.delete();
        rd_prob = 100;
        @(negedge clk);
        for (int i = 0; i < N; i++) push_pkt(i, 8, 1'b1);
        wait_idle(300, "t2_drain");
        chk("t2_ngrants", glog.size() >= 5, 1);
        for (int k = 0; k < 5; k++) chk("t2_order", glog[k], k % N);
        for (int k = 0; k < 4; k++) chk("t2_beats", blog[k], MB);
        for (int k = 0; k < 4; k++) chk("t2_spacing", gcyc[k+1] - gcyc[k], MB + 1);

        // 3: fill to full and resume after one read
        rd_prob = 0;
        @(negedge clk);
        push_pkt(1, 10, 1'b0);
        wait_level(7, 80, "t3_fill");
        @(negedge clk);
        chk("t3_full", fifo_full, 1);
        chk("t3_ready", req_ready[1], 0);
        chk("t3_wen", fifo_w_en, 0);
        chk("t3_grant", grant, 4'b0010);
        chk("t3_level", fifo_level, 7);
        rd_pulse = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_level_dip", fifo_level, 6);
        @(negedge clk);
        chk("t3_level_back", fifo_level, 7);
        rd_prob = 50;
        wait_idle(300, "t3_drain");

        // 4: simultaneous read and write hold the level
        rd_prob = 0;
        @(negedge clk);
        push_pkt(2, 2, 1'b0);
        wait_level(2, 30, "t4_pre");
        @(negedge clk);
        push_pkt(3, 4, 1'b0);
        wait_grant(4'b1000, 30, "t4_grant");
        rd_prob = 100;
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("t4_level_hold", fifo_level, 3);
        end
        wait_level(0, 30, "t4_drain");
        chk("t4_empty_err", level_err, 0);
        wait_idle(50, "t4_idle");

        // 5: asynchronous reset in the middle of a burst
        rd_prob = 0;
        @(negedge clk);
        push_pkt(0, 4, 1'b0);
        wait_grant(4'b0001, 30, "t5_grant");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_queues();
        #1;
        chk("t5_async_grant", grant, 0);
        chk("t5_async_level", fifo_level, 0);
        chk("t5_async_wen", fifo_w_en, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        push_pkt(2, 2, 1'b0);
        push_pkt(0, 2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_first", grant, 4'b0001);
        rd_prob = 100;
        wait_idle(100, "t5_idle");

        // 6: forced empty flag while entries are held
        rd_prob = 0;
        @(negedge clk);
        push_pkt(1, 2, 1'b0);
        wait_level(2, 30, "t6_pre");
        @(negedge clk);
        @(posedge clk);
        #2 force_empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_err_set", level_err, 1);
        @(posedge clk);
        #2 force_empty = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", level_err, 1);
        do_reset();
        @(negedge clk);
        chk("t6_err_cleared", level_err, 0);

        // random traffic
        gap_prob = 30;
        rd_prob  = 45;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() < 3 && $urandom_range(99) < 10)
                    push_pkt(i, $urandom_range(1, 6), 1'b0);
            end
        end
        gap_prob = 0;
        rd_prob  = 100;
        wait_idle(600, "rand_drain");
        begin
            int left;
            left = 0;
            for (int i = 0; i < N; i++) left += expq[i].size();
            chk("rand_all_written", left, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
